// File: rtl/box_draw_arbiter_if.sv
// Handshake bundle between the box sources, the arbiter and the box drawer.
// The master view belongs to the arbiter. The slave view is the environment:
// the sources and the drawer together.
interface box_draw_arbiter_if #(
    parameter int N_REQ   = 4,
    parameter int COORD_W = 9,
    parameter int COLOR_W = 3,
    parameter int GNT_W   = 2
);
    logic                       pause;
    logic [N_REQ-1:0]           s_valid;
    logic [N_REQ-1:0]           s_ready;
    logic [N_REQ*COORD_W-1:0]   s_box_x;
    logic [N_REQ*COORD_W-1:0]   s_box_y;
    logic [N_REQ*COORD_W-1:0]   s_box_w;
    logic [N_REQ*COORD_W-1:0]   s_box_h;
    logic [N_REQ*COLOR_W-1:0]   s_box_color;
    logic                       m_valid;
    logic                       m_ready;
    logic [COORD_W-1:0]         m_box_x;
    logic [COORD_W-1:0]         m_box_y;
    logic [COORD_W-1:0]         m_box_w;
    logic [COORD_W-1:0]         m_box_h;
    logic [COLOR_W-1:0]         m_box_color;
    logic [GNT_W-1:0]           grant_id;
    logic                       busy;

    modport master (
        input  pause, s_valid, s_box_x, s_box_y, s_box_w, s_box_h, s_box_color, m_ready,
        output s_ready, m_valid, m_box_x, m_box_y, m_box_w, m_box_h, m_box_color,
               grant_id, busy
    );

    modport slave (
        output pause, s_valid, s_box_x, s_box_y, s_box_w, s_box_h, s_box_color, m_ready,
        input  s_ready, m_valid, m_box_x, m_box_y, m_box_w, m_box_h, m_box_color,
               grant_id, busy
    );
endinterface

// File: rtl/box_draw_arbiter.sv
// Round-robin arbiter that shares one box drawer among the paddle, ball and
// score sources. It grants one source per IDLE cycle, registers that
// source's descriptor, and holds it toward the drawer until it is accepted.
module box_draw_arbiter #(
    parameter int N_REQ   = 4,
    parameter int COORD_W = 9,
    parameter int COLOR_W = 3,
    parameter int GNT_W   = 2
) (
    input  logic               clock,
    input  logic               reset,
    box_draw_arbiter_if.master bus
);
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } state_t;

    state_t             r_state;
    logic [GNT_W-1:0]   r_last_grant;
    logic [GNT_W-1:0]   r_grant_id;
    logic               r_m_valid;
    logic               r_busy;
    logic [COORD_W-1:0] r_box_x;
    logic [COORD_W-1:0] r_box_y;
    logic [COORD_W-1:0] r_box_w;
    logic [COORD_W-1:0] r_box_h;
    logic [COLOR_W-1:0] r_box_color;

    logic [COORD_W-1:0] w_req_x     [N_REQ];
    logic [COORD_W-1:0] w_req_y     [N_REQ];
    logic [COORD_W-1:0] w_req_w     [N_REQ];
    logic [COORD_W-1:0] w_req_h     [N_REQ];
    logic [COLOR_W-1:0] w_req_color [N_REQ];

    logic               w_found;
    logic [GNT_W-1:0]   w_winner;
    logic               w_take;
    logic [N_REQ-1:0]   w_s_ready;

    // Unpack the flattened per-source descriptor buses.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign w_req_x[gi]     = bus.s_box_x[gi*COORD_W +: COORD_W];
            assign w_req_y[gi]     = bus.s_box_y[gi*COORD_W +: COORD_W];
            assign w_req_w[gi]     = bus.s_box_w[gi*COORD_W +: COORD_W];
            assign w_req_h[gi]     = bus.s_box_h[gi*COORD_W +: COORD_W];
            assign w_req_color[gi] = bus.s_box_color[gi*COLOR_W +: COLOR_W];
        end
    endgenerate

    // Round-robin search. Scan starts one past the last grant and wraps,
    // so indices at or above N_REQ are never visited.
    always_comb begin
        int idx;
        w_found  = 1'b0;
        w_winner = '0;
        idx      = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = int'(r_last_grant) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!w_found && bus.s_valid[GNT_W'(idx)]) begin
                w_found  = 1'b1;
                w_winner = GNT_W'(idx);
            end
        end
    end

    // A transfer from a source happens only in IDLE, when not paused, and outside reset.
    assign w_take = reset && (r_state == ST_IDLE) && !bus.pause && w_found;

    // One-hot accept toward the winning source, valid for this cycle only.
    always_comb begin
        w_s_ready = '0;
        if (w_take) begin
            w_s_ready[w_winner] = 1'b1;
        end
    end

    // Two-state grant/offer machine with registered drawer-side outputs.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_last_grant <= GNT_W'(N_REQ - 1);
            r_grant_id   <= '0;
            r_m_valid    <= 1'b0;
            r_busy       <= 1'b0;
            r_box_x      <= '0;
            r_box_y      <= '0;
            r_box_w      <= '0;
            r_box_h      <= '0;
            r_box_color  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_take) begin
                        r_box_x      <= w_req_x[w_winner];
                        r_box_y      <= w_req_y[w_winner];
                        r_box_w      <= w_req_w[w_winner];
                        r_box_h      <= w_req_h[w_winner];
                        r_box_color  <= w_req_color[w_winner];
                        r_grant_id   <= w_winner;
                        r_last_grant <= w_winner;
                        r_m_valid    <= 1'b1;
                        r_busy       <= 1'b1;
                        r_state      <= ST_OFFER;
                    end
                end
                ST_OFFER: begin
                    if (bus.m_ready) begin
                        r_m_valid <= 1'b0;
                        r_busy    <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_m_valid <= 1'b0;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.s_ready     = w_s_ready;
    assign bus.m_valid     = r_m_valid;
    assign bus.m_box_x     = r_box_x;
    assign bus.m_box_y     = r_box_y;
    assign bus.m_box_w     = r_box_w;
    assign bus.m_box_h     = r_box_h;
    assign bus.m_box_color = r_box_color;
    assign bus.grant_id    = r_grant_id;
    assign bus.busy        = r_busy;
endmodule

// File: tb/tb_box_draw_arbiter.sv
// Scoreboard bench for box_draw_arbiter. A reference model predicts each grant
// from the round-robin rule and queues the expected descriptor. A separate
// monitor pops and compares each descriptor when the drawer accepts it.
module tb_box_draw_arbiter;
    localparam int N  = 4;
    localparam int CW = 9;
    localparam int KW = 3;
    localparam int GW = 2;

    typedef struct packed {
        logic [GW-1:0] g;
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        logic [CW-1:0] w;
        logic [CW-1:0] h;
        logic [KW-1:0] c;
    } exp_t;

    logic clock;
    logic reset;

    box_draw_arbiter_if #(.N_REQ(N), .COORD_W(CW), .COLOR_W(KW), .GNT_W(GW)) bus ();

    box_draw_arbiter #(.N_REQ(N), .COORD_W(CW), .COLOR_W(KW), .GNT_W(GW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #10 clock = ~clock;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb[$];
    int   glog[$];

    // Stimulus policy, written only by the main process.
    logic [N-1:0]  hold_mask = '0;
    logic [N-1:0]  once_mask = '0;
    int            once_seq  = 0;
    int            pct       = 0;
    int            drop_pct  = 0;
    logic [N-1:0]  fix_en    = '0;
    logic [CW-1:0] fix_x [N];
    logic [CW-1:0] fix_y [N];
    logic [CW-1:0] fix_w [N];
    logic [CW-1:0] fix_h [N];
    logic [KW-1:0] fix_c [N];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    function automatic int rr_pick(input int last, input logic [N-1:0] v);
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (last + k) % N;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    // Source driver: keeps each requester's valid/fields stable until its s_ready is seen.
    initial begin
        logic [N-1:0] sr;
        logic [N-1:0] newreq;
        int           once_seen;
        once_seen       = 0;
        bus.s_valid     = '0;
        bus.s_box_x     = '0;
        bus.s_box_y     = '0;
        bus.s_box_w     = '0;
        bus.s_box_h     = '0;
        bus.s_box_color = '0;
        forever begin
            @(negedge clock);
            sr = bus.s_ready;
            @(posedge clock);
            #1;
            newreq = '0;
            if (once_seq != once_seen) begin
                newreq    = once_mask;
                once_seen = once_seq;
            end
            for (int i = 0; i < N; i++) begin
                if (bus.s_valid[i] && sr[i]) begin
                    bus.s_valid[i] = 1'b0;
                end else if (bus.s_valid[i] && !hold_mask[i] && drop_pct > 0
                             && int'($urandom_range(99)) < drop_pct) begin
                    bus.s_valid[i] = 1'b0;
                end
                if (!bus.s_valid[i] && (hold_mask[i] || newreq[i] || int'($urandom_range(99)) < pct)) begin
                    bus.s_valid[i] = 1'b1;
                    if (fix_en[i]) begin
                        bus.s_box_x[i*CW +: CW]     = fix_x[i];
                        bus.s_box_y[i*CW +: CW]     = fix_y[i];
                        bus.s_box_w[i*CW +: CW]     = fix_w[i];
                        bus.s_box_h[i*CW +: CW]     = fix_h[i];
                        bus.s_box_color[i*KW +: KW] = fix_c[i];
                    end else begin
                        bus.s_box_x[i*CW +: CW]     = CW'($urandom);
                        bus.s_box_y[i*CW +: CW]     = CW'($urandom);
                        bus.s_box_w[i*CW +: CW]     = CW'($urandom);
                        bus.s_box_h[i*CW +: CW]     = CW'($urandom);
                        bus.s_box_color[i*KW +: KW] = KW'($urandom);
                    end
                end
            end
        end
    end

    // Reference model: predicts the accept pulse and queues the granted descriptor.
    initial begin
        int   last;
        bit   mbusy;
        int   w;
        exp_t e;
        last  = N - 1;
        mbusy = 1'b0;
        forever begin
            @(negedge clock);
            chk("m_valid", 32'(bus.m_valid), 32'(mbusy));
            if (!reset) begin
                chk("s_ready_in_reset", 32'(bus.s_ready), 0);
                sb.delete();
                mbusy = 1'b0;
                last  = N - 1;
            end else begin
                chk("busy", 32'(bus.busy), 32'(mbusy));
                if (mbusy) begin
                    chk("s_ready_offer", 32'(bus.s_ready), 0);
                    if (bus.m_ready) mbusy = 1'b0;
                end else begin
                    w = bus.pause ? -1 : rr_pick(last, bus.s_valid);
                    if (w >= 0) begin
                        chk("s_ready_grant", 32'(bus.s_ready), 32'(1) << w);
                        e.g = GW'(w);
                        e.x = bus.s_box_x[w*CW +: CW];
                        e.y = bus.s_box_y[w*CW +: CW];
                        e.w = bus.s_box_w[w*CW +: CW];
                        e.h = bus.s_box_h[w*CW +: CW];
                        e.c = bus.s_box_color[w*KW +: KW];
                        sb.push_back(e);
                        last  = w;
                        mbusy = 1'b1;
                    end else begin
                        chk("s_ready_idle", 32'(bus.s_ready), 0);
                    end
                end
            end
        end
    end

    // Monitor: compares every descriptor the drawer accepts against the queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (reset && bus.m_valid && bus.m_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_box", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("grant_id", 32'(bus.grant_id), 32'(e.g));
                    chk("m_box_x", 32'(bus.m_box_x), 32'(e.x));
                    chk("m_box_y", 32'(bus.m_box_y), 32'(e.y));
                    chk("m_box_w", 32'(bus.m_box_w), 32'(e.w));
                    chk("m_box_h", 32'(bus.m_box_h), 32'(e.h));
                    chk("m_box_color", 32'(bus.m_box_color), 32'(e.c));
                    $display("box: grant=%0d x=%0d y=%0d w=%0d h=%0d c=%0d",
                             bus.grant_id, bus.m_box_x, bus.m_box_y, bus.m_box_w,
                             bus.m_box_h, bus.m_box_color);
                    glog.push_back(int'(bus.grant_id));
                end
            end
        end
    end

    task automatic wait_mvalid(input string nm);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clock);
            seen = bus.m_valid;
        end
        chk(nm, 32'(seen), 1);
    endtask

    task automatic wait_glog(input string nm, input int n);
        for (int i = 0; i < 60 && glog.size() < n; i++) @(negedge clock);
        chk(nm, 32'(glog.size() >= n), 1);
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clock);
            done = (bus.s_valid == '0) && !bus.m_valid;
        end
        chk("drain", 32'(done), 1);
        cyc();
    endtask

    task automatic request(input logic [N-1:0] m);
        once_mask = m;
        once_seq++;
    endtask

    initial begin
        int pos;
        for (int i = 0; i < N; i++) begin
            fix_x[i] = '0; fix_y[i] = '0; fix_w[i] = '0; fix_h[i] = '0; fix_c[i] = '0;
        end
        reset       = 1'b0;
        bus.pause   = 1'b0;
        bus.m_ready = 1'b0;
        repeat (3) cyc();

        // Reset values.
        @(negedge clock);
        chk("rst_m_valid", 32'(bus.m_valid), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_grant_id", 32'(bus.grant_id), 0);
        chk("rst_m_box_x", 32'(bus.m_box_x), 0);
        chk("rst_m_box_color", 32'(bus.m_box_color), 0);

        // Ordering with all sources held valid.
        cyc();
        hold_mask   = '1;
        bus.m_ready = 1'b1;
        reset       = 1'b1;
        glog.delete();
        wait_glog("order_timeout", 5);
        if (glog.size() >= 5) begin
            chk("order0", 32'(glog[0]), 0);
            chk("order1", 32'(glog[1]), 1);
            chk("order2", 32'(glog[2]), 2);
            chk("order3", 32'(glog[3]), 3);
            chk("order4", 32'(glog[4]), 0);
        end
        cyc();
        hold_mask = '0;
        drain();

        // Descriptor routing from requester 2.
        fix_en[2] = 1'b1;
        fix_x[2] = 9'd150; fix_y[2] = 9'd100; fix_w[2] = 9'd4; fix_h[2] = 9'd4; fix_c[2] = 3'd7;
        request(4'b0100);
        wait_mvalid("route_timeout");
        chk("route_grant", 32'(bus.grant_id), 2);
        chk("route_x", 32'(bus.m_box_x), 150);
        chk("route_y", 32'(bus.m_box_y), 100);
        chk("route_color", 32'(bus.m_box_color), 7);
        drain();

        // Backpressure with requesters 1 and 3 queuing behind requester 0.
        fix_en[0] = 1'b1;
        fix_x[0] = 9'd0; fix_y[0] = 9'd96; fix_w[0] = 9'd10; fix_h[0] = 9'd48; fix_c[0] = 3'd5;
        bus.m_ready = 1'b0;
        glog.delete();
        request(4'b0001);
        wait_mvalid("bp_timeout");
        cyc();
        request(4'b1010);
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            chk("bp_s_ready", 32'(bus.s_ready), 0);
            chk("bp_busy", 32'(bus.busy), 1);
            chk("bp_y", 32'(bus.m_box_y), 96);
            chk("bp_w", 32'(bus.m_box_w), 10);
            chk("bp_h", 32'(bus.m_box_h), 48);
        end
        cyc();
        bus.m_ready = 1'b1;
        wait_glog("bp_order_timeout", 3);
        if (glog.size() >= 3) begin
            chk("bp_order0", 32'(glog[0]), 0);
            chk("bp_order1", 32'(glog[1]), 1);
            chk("bp_order2", 32'(glog[2]), 3);
        end
        drain();
        fix_en = '0;

        // Pause while idle, then pause while a box is offered.
        bus.pause = 1'b1;
        hold_mask = '1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            chk("pause_s_ready", 32'(bus.s_ready), 0);
            chk("pause_m_valid", 32'(bus.m_valid), 0);
        end
        cyc();
        bus.m_ready = 1'b0;
        bus.pause   = 1'b0;
        wait_mvalid("pause_offer_timeout");
        cyc();
        bus.pause = 1'b1;
        repeat (2) cyc();
        bus.m_ready = 1'b1;
        repeat (2) @(negedge clock);
        chk("pause_offer_done", 32'(bus.m_valid), 0);
        repeat (4) cyc();
        hold_mask = '0;
        bus.pause = 1'b0;
        drain();

        // Reset while a box is offered.
        bus.m_ready = 1'b0;
        request(4'b0100);
        wait_mvalid("rst_offer_timeout");
        cyc();
        reset = 1'b0;
        cyc();
        @(negedge clock);
        chk("midrst_m_valid", 32'(bus.m_valid), 0);
        chk("midrst_busy", 32'(bus.busy), 0);
        chk("midrst_grant_id", 32'(bus.grant_id), 0);
        chk("midrst_m_box_x", 32'(bus.m_box_x), 0);
        cyc();
        reset = 1'b1;
        glog.delete();
        request(4'b1111);
        bus.m_ready = 1'b1;
        wait_glog("midrst_grant_timeout", 1);
        if (glog.size() >= 1) chk("midrst_first", 32'(glog[0]), 0);
        drain();

        // Fairness: requester 3 breaks into a stream from requester 1.
        hold_mask = 4'b0010;
        repeat (5) cyc();
        glog.delete();
        request(4'b1000);
        pos = -1;
        for (int i = 0; i < 12 && pos < 0; i++) begin
            @(negedge clock);
            foreach (glog[k]) if (glog[k] == 3 && pos < 0) pos = k;
        end
        chk("fair_seen", 32'(pos >= 0), 1);
        chk("fair_within2", 32'(pos >= 0 && pos <= 2), 1);
        cyc();
        hold_mask = '0;
        drain();

        // Randomized traffic with random pause, backpressure and rare resets.
        pct      = 30;
        drop_pct = 5;
        for (int i = 0; i < 3000; i++) begin
            cyc();
            bus.pause   = ($urandom_range(9) == 0);
            bus.m_ready = ($urandom_range(99) < 60);
            reset       = ($urandom_range(399) != 0);
        end
        cyc();
        pct         = 0;
        drop_pct    = 0;
        bus.pause   = 1'b0;
        bus.m_ready = 1'b1;
        reset       = 1'b1;
        drain();
        repeat (2) cyc();
        chk("sb_empty", 32'(sb.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/box_draw_arbiter.md
Name: box_draw_arbiter

Overview:
- Shares the single box drawer among several box sources: left paddle, right paddle, ball and score/overlay.
- Each source offers one box descriptor (x, y, w, h, colour) on a valid/ready handshake.
- The arbiter picks one source at a time in round-robin order and registers its descriptor.
- It then presents that descriptor to the box drawer on a second valid/ready handshake. One box is in flight at a time.

Parameters:
- N_REQ, 4, number of requester ports. Index 0 = left paddle, 1 = right paddle, 2 = ball, 3 = score.
- COORD_W, 9, width of each x/y/w/h field.
- COLOR_W, 3, width of the colour field.
- GNT_W, 2, width of the grant index. Must satisfy 2^GNT_W >= N_REQ.

Ports:
- clock  in  1  system clock (50 MHz)
- reset  in  1  synchronous, active-low reset
- pause  in  1  when high, no new grant is issued; an in-flight box still completes
- s_valid  in  N_REQ  per-requester descriptor valid
- s_ready  out  N_REQ  per-requester accept; one-hot pulse
- s_box_x  in  N_REQ*COORD_W  flattened x; requester i occupies bits [i*COORD_W +: COORD_W]
- s_box_y  in  N_REQ*COORD_W  flattened y
- s_box_w  in  N_REQ*COORD_W  flattened width
- s_box_h  in  N_REQ*COORD_W  flattened height
- s_box_color  in  N_REQ*COLOR_W  flattened colour
- m_valid  out  1  descriptor valid toward the box drawer
- m_ready  in  1  box drawer ready (idle)
- m_box_x / m_box_y / m_box_w / m_box_h  out  COORD_W each  registered descriptor
- m_box_color  out  COLOR_W  registered colour
- grant_id  out  GNT_W  index of the requester whose box is currently held
- busy  out  1  high while in OFFER state

Behaviour:
- Clocking: all state updates on posedge clock. Reset is checked first and overrides everything.
- Reset values:
  - State = IDLE.
  - s_ready = 0, m_valid = 0, busy = 0.
  - m_box_x/y/w/h = 0, m_box_color = 0, grant_id = 0.
  - last_grant = N_REQ-1, so requester 0 wins first after reset.
- State machine: two states, IDLE and OFFER.
- IDLE, when pause=0 and any s_valid is high:
  - Select winner i: the first valid index searching last_grant+1, last_grant+2, … modulo N_REQ.
  - s_ready is combinational: s_ready[i]=1 for this cycle only, all other bits 0. The requester transfer completes in this same cycle.
  - On the clock edge: latch requester i's fields into m_box_*, set grant_id=i and last_grant=i, set m_valid=1, go to OFFER.
- IDLE, when pause=1 or no s_valid: s_ready = 0, stay in IDLE, outputs hold.
- OFFER:
  - s_ready = 0 on every port.
  - m_valid=1 and m_box_* stay stable until m_valid && m_ready.
  - On that edge: m_valid=0, go to IDLE.
  - pause has no effect in OFFER.
- Latency and throughput:
  - Requester accept at cycle N; m_valid rises at cycle N+1.
  - Minimum of 2 cycles per box (one IDLE cycle plus one OFFER cycle with m_ready=1).
- A requester must hold s_valid and its fields stable until it sees its s_ready bit. A requester dropping s_valid before being granted loses nothing.
- Boundary conditions:
  - Requester whose valid is held continuously: re-granted only after every other currently-valid requester has had one grant.
  - Single active requester: served every 2 cycles.
  - Wrap-around: winner search after last_grant = N_REQ-1 starts at index 0.
  - Simultaneous s_valid deassert and grant in the same cycle: not possible; the grant is sampled combinationally from the current s_valid.
  - Reset asserted during OFFER: the box is dropped, m_valid=0 on the next edge. No partial handshake occurs on either side.
  - m_ready high while in IDLE: ignored.
  - N_REQ values that are not a power of two: indices >= N_REQ are never granted.

Test Plan:
1. Reset and ordering: apply reset, release; s_valid=4'b1111, m_ready=1 held. Required: s_ready pulses 0001, 0010, 0100, 1000, 0001 every second cycle; grant_id sequence 0,1,2,3,0.
2. Descriptor routing: requester 2 only, x=150, y=100, w=4, h=4, colour=3'b111. Required: s_ready=0100 for one cycle; next cycle m_valid=1 with m_box_x=150, m_box_y=100, m_box_w=4, m_box_h=4, m_box_color=7, grant_id=2.
3. Backpressure: requester 0 (x=0, y=96, w=10, h=48) is granted, then m_ready=0 for 10 cycles while requesters 1 and 3 assert valid. Required: m_box_* stable, s_ready=0, busy=1 throughout. After m_ready=1, the next grant goes to requester 1, then to requester 3.
4. Pause: pause=1 with all requesters valid for 8 cycles. Required: no s_ready pulse and m_valid=0. Pause asserted while in OFFER: the held box still completes on m_ready.
5. Reset mid-offer: reset=0 during OFFER with m_ready=0. Required: the next cycle has m_valid=0 and all outputs at reset values; after release, requester 0 is granted first.
6. Fairness: requester 1 valid constantly, requester 3 asserts valid once. Required: requester 3 is granted within 2 grants, i.e. within 4 cycles with m_ready=1.
